bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one iterative (one bit per clock) shift-add-3 binary-to-BCD engine among NUM_REQ requesters, e.g. score, timer and high-score counters feeding the seven-segment path.
- Arbitration is round-robin.
- Each conversion takes a fixed number of cycles.
- The result is returned on a single response bus tagged with the requester id; it replaces per-requester combinational converters.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BIN_W, 14, binary input width per requester.
- DIGITS, 4, BCD digits produced (DIGITS*4-bit result).
- MAX_VAL, 9999, saturation limit; larger inputs convert as MAX_VAL.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_bin  in  NUM_REQ*BIN_W  packed binary values; requester i at [i*BIN_W +: BIN_W].
- req_ready  out  NUM_REQ  one-hot grant/accept; combinational.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the result.
- rsp_bcd  out  DIGITS*4  result; digit 0 (ones) in [3:0], thousands in the top nibble.
- rsp_ovf  out  1  input exceeded MAX_VAL and was saturated.
- busy  out  1  high in SHIFT and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n: it asserts immediately and releases synchronously to clk.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_bcd=0, rsp_ovf=0, busy=0.
  - req_ready=0 while rst_n=0.
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant g is the first index with req_valid set, searching from rr_ptr+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits are 0. With no valid requests, req_ready=0.
  - Accept edge (req_valid[g]&req_ready[g]):
    - Load the shift register with {zeros, min(req_bin[g], MAX_VAL)}.
    - Latch id=g and ovf=(req_bin[g]>MAX_VAL).
    - Set rr_ptr=g, cnt=0, and move to SHIFT.
- SHIFT:
  - Each edge performs one iteration: add 3 to every BCD nibble >=5, then shift left 1.
  - cnt increments each edge. On the edge where cnt==BIN_W-1, move to DONE, so exactly BIN_W iterations run.
  - req_ready=0 throughout.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - rsp_bcd, rsp_id and rsp_ovf are registered and remain stable until the next DONE.
  - Next edge returns to IDLE.
- Latency and throughput:
  - Accept edge E0; rsp_valid is high in the cycle after edge E(BIN_W), i.e. E14 for the defaults.
  - Earliest next accept is edge E(BIN_W+1).
  - Throughput is 1 conversion per BIN_W+1 cycles.
- Width rules:
  - Shift register is DIGITS*4+BIN_W bits.
  - Nibble add-3 wraps within 4 bits; it cannot overflow for inputs <=MAX_VAL.
  - Saturation compares against MAX_VAL at full BIN_W width.
- Boundary conditions:
  - Input 0 gives rsp_bcd=0.
  - MAX_VAL gives 16'h9999.
  - Input 16383 gives 16'h9999 with rsp_ovf=1.
- Requester behaviour:
  - Requesters need not hold req_valid while not granted; a dropped request is simply not served.
  - req_bin is sampled only on the accept edge; later changes do not affect the conversion in flight.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that keeps req_valid high is served again only after every other active requester has been served once.
- Reset mid-conversion: aborts immediately, produces no rsp_valid, the request is lost and the requester must reissue. After release, arbitration restarts at requester 0.

Decomposition:
- Package bcd_pkg holds:
  - constants BIN_W=14, DIGITS=4, MAX_VAL=9999;
  - state enum {IDLE, SHIFT, DONE};
  - a function computing the shift-register width.
- One sub-module, bcd_dd_step: combinational, one double-dabble iteration (add-3 on every nibble, then shift left 1). Instantiated once in SHIFT; it is also unit-testable on its own.

Test Plan:
- Single request: req_valid=3'b001, req_bin[0]=1234 -> req_ready=001 at E0; rsp_valid one cycle after E14; rsp_bcd=16'h1234, rsp_id=0, rsp_ovf=0; busy high E0..E15.
- Boundaries: convert 0, 9, 10, 99, 9999 in sequence -> 16'h0000, 0009, 0010, 0099, 9999; back-to-back accept spacing of exactly 15 cycles.
- Saturation: req_bin=16383 -> rsp_bcd=16'h9999, rsp_ovf=1; next request with 42 -> 16'h0042, rsp_ovf=0.
- Round-robin: all three valid, held high with values 11/22/33 -> rsp_id order 0,1,2,0,1,…, values matching their ids; no requester served twice before the others.
- Reset mid-SHIFT: assert rst_n=0 at E7 of a conversion -> all outputs 0 immediately, no rsp_valid. After release with requesters 1 and 2 valid -> first grant goes to 1.
- Input change and drop: change req_bin[0] after accept -> result reflects the sampled value. Drop req_valid[2] while 1 is converting -> requester 2 is never granted.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper
// for the shared binary-to-BCD conversion engine.
package bcd_pkg;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // BCD digits on top, binary operand underneath.
  function automatic int sr_width(input int bin_w,
                                  input int digits);
    return digits * 4 + bin_w;
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD
// nibble >= 5, then shift the whole register left.
module bcd_dd_step #(
  parameter int BIN_W  = bcd_pkg::BIN_W,
  parameter int DIGITS = bcd_pkg::DIGITS,
  parameter int SRW    = bcd_pkg::sr_width(BIN_W, DIGITS)
) (
  input  logic [SRW-1:0] sr_i,
  output logic [SRW-1:0] sr_o
);

  logic [SRW-1:0] adj;

  // Correct each digit so the following shift
  // carries into the next decimal position.
  always_comb begin
    adj = sr_i;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_i[BIN_W+4*d +: 4] >= 4'd5) begin
        adj[BIN_W+4*d +: 4] = sr_i[BIN_W+4*d +: 4] + 4'd3;
      end
    end
    sr_o = adj << 1;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin front end sharing one iterative
// binary-to-BCD engine among NUM_REQ requesters.
module bcd_conv_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int BIN_W   = bcd_pkg::BIN_W,
  parameter int DIGITS  = bcd_pkg::DIGITS,
  parameter int MAX_VAL = bcd_pkg::MAX_VAL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BIN_W-1:0]   req_bin,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DIGITS*4-1:0]        rsp_bcd,
  output logic                       rsp_ovf,
  output logic                       busy
);

  import bcd_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SRW = sr_width(BIN_W, DIGITS);
  localparam int CW  = $clog2(BIN_W);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SRW-1:0]       sr_q, sr_d;
  logic [IDW-1:0]       rid_q, rid_d;
  logic [DIGITS*4-1:0]  rbcd_q, rbcd_d;
  logic                 rovf_q, rovf_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDW-1:0]       g;
  logic                 found;
  logic [IDW:0]         s;
  logic [BIN_W-1:0]     sel_bin;
  logic [BIN_W-1:0]     sat_bin;
  logic                 ovf_in;
  logic                 accept;
  logic                 arb_en;
  logic [SRW-1:0]       step_o;

  bcd_dd_step #(
    .BIN_W (BIN_W),
    .DIGITS(DIGITS),
    .SRW   (SRW)
  ) u_step (
    .sr_i(sr_q),
    .sr_o(step_o)
  );

  // Search for the first valid requester after the
  // one served last, wrapping modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    g     = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = {1'b0, rr_q} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NUM_REQ)) begin
        s = s - (IDW+1)'(NUM_REQ);
      end
      if (!found && req_valid[s[IDW-1:0]]) begin
        found = 1'b1;
        g     = s[IDW-1:0];
      end
    end
    if (found) begin
      gnt[g] = 1'b1;
    end
  end

  // Arbitration also runs in DONE so the next job
  // starts on the edge that retires the current one.
  assign arb_en    = rst_n &&
                     (state_q == IDLE || state_q == DONE);
  assign req_ready = arb_en ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_bin   = req_bin[g*BIN_W +: BIN_W];
  assign ovf_in    = sel_bin > BIN_W'(MAX_VAL);
  assign sat_bin   = ovf_in ? BIN_W'(MAX_VAL) : sel_bin;

  // Sequencing: load on accept, iterate, publish.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rid_d   = rid_q;
    rbcd_d  = rbcd_q;
    rovf_d  = rovf_q;
    unique case (state_q)
      SHIFT: begin
        sr_d  = step_o;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W-1)) begin
          state_d = DONE;
          rbcd_d  = step_o[SRW-1 -: DIGITS*4];
          rid_d   = id_q;
          rovf_d  = ovf_q;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          sr_d    = SRW'(sat_bin);
          id_d    = g;
          ovf_d   = ovf_in;
          rr_d    = g;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= IDW'(NUM_REQ-1);
      id_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      rid_q   <= '0;
      rbcd_q  <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rid_q   <= rid_d;
      rbcd_q  <= rbcd_d;
      rovf_q  <= rovf_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rid_q;
  assign rsp_bcd   = rbcd_q;
  assign rsp_ovf   = rovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with an
// expected-result queue checked on every strobe.
module tb_bcd_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [41:0] req_bin;
  logic [2:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_bcd;
  logic        rsp_ovf;
  logic        busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last   = 2;

  bcd_conv_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_bin  (req_bin),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_bcd  (rsp_bcd),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10),
            4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic int next_grant(input logic [2:0] v);
    int r;
    int i;
    r = -1;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k) % 3;
      if (r < 0 && v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return (i < 0) ? 3'b000 : 3'(1 << i);
  endfunction

  task automatic drive_bin(input int id, input int val);
    req_bin[id*14 +: 14] = 14'(val);
  endtask

  task automatic push(input int id, input int val);
    exp_t e;
    e.id  = 2'(id);
    e.bcd = to_bcd(val);
    e.ovf = (val > 9999);
    sb.push_back(e);
    last = id;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed id=%0d expected=none",
               rsp_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic run_one(input int id, input int val);
    int eg;
    req_valid = onehot(id);
    drive_bin(id, val);
    #1;
    eg = next_grant(req_valid);
    chk("ready_single", 32'(req_ready), 32'(onehot(eg)));
    push(eg, val);
    @(posedge clk); #1;
    req_valid = 3'b000;
    drive_bin(id, 16383 - val);
    chk("busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      chk("rsp_valid_lat", 32'(rsp_valid), 32'(k == 14));
      chk("busy_lat", 32'(busy), 32'(k < 15));
    end
    chk("rsp_hold", 32'(rsp_bcd), 32'(to_bcd(val)));
  endtask

  initial begin
    int     vals[5];
    int     n;
    int     eg;
    longint t;
    longint prev;

    vals = '{0, 9, 10, 99, 9999};
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_bin   = '0;
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_bcd", 32'(rsp_bcd), 32'd0);
    chk("rst_ovf", 32'(rsp_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    req_valid = 3'b000;
    rst_n     = 1'b1;
    last      = 2;
    @(posedge clk); #1;

    run_one(0, 1234);

    req_valid = 3'b001;
    drive_bin(0, vals[0]);
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      #1;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_wait", 32'(n < 40), 32'd1);
      eg = next_grant(req_valid);
      chk("b2b_ready", 32'(req_ready), 32'(onehot(eg)));
      push(eg, vals[j]);
      @(posedge clk);
      t = $time;
      if (j > 0) chk("b2b_spacing", 32'((t - prev) / 10), 32'd15);
      prev = t;
      #1;
      if (j < 4) drive_bin(0, vals[j+1]);
      else req_valid = 3'b000;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_drain", 32'(sb.size()), 32'd0);

    run_one(0, 16383);
    run_one(0, 42);

    req_valid = 3'b111;
    drive_bin(0, 11);
    drive_bin(1, 22);
    drive_bin(2, 33);
    for (int r = 0; r < 6; r++) begin
      #1;
      n = 0;
      while (req_ready === 3'b000 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("rr_wait", 32'(n < 40), 32'd1);
      eg = next_grant(req_valid);
      chk("rr_ready", 32'(req_ready), 32'(onehot(eg)));
      push(eg, 11 * (eg + 1));
      @(posedge clk);
    end
    #1;
    req_valid = 3'b000;
    repeat (20) @(posedge clk);
    #1;
    chk("rr_drain", 32'(sb.size()), 32'd0);

    req_valid = 3'b001;
    drive_bin(0, 500);
    drive_bin(1, 3210);
    @(posedge clk); #1;
    req_valid = 3'b000;
    repeat (7) @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 3'b110;
    #1;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(rsp_bcd), 32'd0);
    chk("abort_id", 32'(rsp_id), 32'd0);
    chk("abort_ovf", 32'(rsp_ovf), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last  = 2;
    #1;
    eg = next_grant(req_valid);
    chk("post_rst_ready", 32'(req_ready), 32'(onehot(eg)));
    push(eg, 3210);
    @(posedge clk); #1;
    req_valid = 3'b000;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      chk("drop_ready", 32'(req_ready), 32'd0);
    end
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
